// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: SFD hunt, PHR length capture and bit-wise payload gating into the output FIFO.
// Optional FCS check (CRC-16 x^16+x^12+x^5+1, LSB-first) is built when RX_FRAME_CTRL_CRC_EN is defined.
module rx_frame_ctrl #(
  parameter logic [7:0]  SFD_PATTERN    = 8'hA7,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned MAX_LEN        = 127
) (
  input  logic       inClock,
  input  logic       inReset,
  input  logic       inEnable,
  input  logic       inBitValid,
  input  logic       inBit,
  input  logic       inFifoFull,
  output logic       outWriteEnable,
  output logic       outData,
  output logic       outFrameActive,
  output logic       outFrameDone,
  output logic       outFrameError,
  output logic [1:0] outErrorCode,
  output logic [6:0] outFrameLength,
  output logic       outCrcOk
);

  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CountW = 10;

  typedef enum logic [2:0] {sIdle, sHunt, sLength, sPayload, sDone, sError} stateT;

  stateT             state, stateNext;
  logic [7:0]        shiftReg, shiftNext, shiftCand;
  logic [CountW-1:0] bitCount, bitCountNext;
  logic [TimerW-1:0] timer, timerNext, timerInc;
  logic [6:0]        lenCand;
  logic              sfdHit, payloadWrite, lastBit, timedOut;
  logic              writeEnableNext, dataNext;
  logic [1:0]        errorCodeNext;
  logic [6:0]        frameLengthNext;

  assign shiftCand    = {inBit, shiftReg[7:1]};
  assign lenCand      = shiftCand[6:0];
  assign timerInc     = timer + TimerW'(1);
  assign timedOut     = (timerInc == TimerW'(TIMEOUT_CYCLES));
  assign sfdHit       = inEnable && (state == sHunt) && inBitValid && (shiftCand == SFD_PATTERN);
  assign payloadWrite = inEnable && (state == sPayload) && inBitValid && !inFifoFull;
  assign lastBit      = (bitCount == CountW'(1));

  // Next-state and next-output logic
  always_comb begin
    stateNext       = state;
    shiftNext       = shiftReg;
    bitCountNext    = bitCount;
    timerNext       = timer;
    writeEnableNext = 1'b0;
    dataNext        = 1'b0;
    errorCodeNext   = outErrorCode;
    frameLengthNext = outFrameLength;

    if (!inEnable) begin
      stateNext = sIdle;
      shiftNext = '0;
      timerNext = '0;
    end else begin
      case (state)
        sIdle: begin
          shiftNext = '0;
          stateNext = sHunt;
        end
        sHunt: begin
          timerNext = '0;
          if (inBitValid) begin
            shiftNext = shiftCand;
            if (sfdHit) begin
              stateNext     = sLength;
              errorCodeNext = 2'b00;
              bitCountNext  = '0;
            end
          end
        end
        sLength: begin
          if (inBitValid) begin
            timerNext    = '0;
            shiftNext    = shiftCand;
            bitCountNext = bitCount + CountW'(1);
            if (bitCount == CountW'(7)) begin
              if (lenCand == 7'd0 || 32'(lenCand) > MAX_LEN) begin
                stateNext     = sError;
                errorCodeNext = 2'b01;
              end else begin
                stateNext       = sPayload;
                frameLengthNext = lenCand;
                bitCountNext    = {lenCand, 3'b000};
              end
            end
          end else if (timedOut) begin
            stateNext     = sError;
            errorCodeNext = 2'b11;
          end else begin
            timerNext = timerInc;
          end
        end
        sPayload: begin
          if (inBitValid) begin
            timerNext = '0;
            if (inFifoFull) begin
              stateNext     = sError;
              errorCodeNext = 2'b10;
            end else begin
              writeEnableNext = 1'b1;
              dataNext        = inBit;
              bitCountNext    = bitCount - CountW'(1);
              if (lastBit) stateNext = sDone;
            end
          end else if (timedOut) begin
            stateNext     = sError;
            errorCodeNext = 2'b11;
          end else begin
            timerNext = timerInc;
          end
        end
        sDone, sError: begin
          // Strobes in this cycle are dropped; the next frame needs a fresh SFD
          shiftNext = '0;
          timerNext = '0;
          stateNext = sHunt;
        end
        default: stateNext = sIdle;
      endcase
    end
  end

  always_ff @(posedge inClock or posedge inReset) begin
    if (inReset) begin
      state          <= sIdle;
      shiftReg       <= '0;
      bitCount       <= '0;
      timer          <= '0;
      outWriteEnable <= 1'b0;
      outData        <= 1'b0;
      outFrameActive <= 1'b0;
      outFrameDone   <= 1'b0;
      outFrameError  <= 1'b0;
      outErrorCode   <= 2'b00;
      outFrameLength <= '0;
    end else begin
      state          <= stateNext;
      shiftReg       <= shiftNext;
      bitCount       <= bitCountNext;
      timer          <= timerNext;
      outWriteEnable <= writeEnableNext;
      outData        <= dataNext;
      outFrameActive <= (stateNext == sLength) || (stateNext == sPayload);
      outFrameDone   <= (stateNext == sDone);
      outFrameError  <= (stateNext == sError);
      outErrorCode   <= errorCodeNext;
      outFrameLength <= frameLengthNext;
    end
  end

`ifdef RX_FRAME_CTRL_CRC_EN
  logic [15:0] crc, crcNext, crcStep;
  logic        crcOkNext;

  // Reflected CCITT polynomial; a frame carrying its own FCS leaves a zero residue
  assign crcStep = {1'b0, crc[15:1]} ^ ((crc[0] ^ inBit) ? 16'h8408 : 16'h0000);

  always_comb begin
    crcNext   = crc;
    crcOkNext = outCrcOk;
    if (sfdHit) begin
      crcNext   = '0;
      crcOkNext = 1'b1;
    end else if (payloadWrite) begin
      crcNext = crcStep;
      if (lastBit) crcOkNext = (crcStep == 16'h0000);
    end
  end

  always_ff @(posedge inClock or posedge inReset) begin
    if (inReset) begin
      crc      <= '0;
      outCrcOk <= 1'b1;
    end else begin
      crc      <= crcNext;
      outCrcOk <= crcOkNext;
    end
  end
`else
  assign outCrcOk = 1'b1;
`endif

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Scoreboard bench for rx_frame_ctrl: stimulus queues expected writes and frame events, a monitor checks them.
module tb_rx_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, bv = 1'b0, b = 1'b0, full = 1'b0;
  logic       outWriteEnable, outData, outFrameActive, outFrameDone, outFrameError, outCrcOk;
  logic [1:0] outErrorCode;
  logic [6:0] outFrameLength;

  typedef struct {logic data; int cyc;} wrT;
  typedef struct {logic isDone; logic [1:0] code; logic [6:0] len; logic crc;} evT;

  wrT wrQ[$];
  evT evQ[$];
  wrT w;
  evT e;
  int compared = 0, mismatched = 0, cyc = 0;

  rx_frame_ctrl dut (
    .inClock(clk), .inReset(rst), .inEnable(en), .inBitValid(bv), .inBit(b), .inFifoFull(full),
    .outWriteEnable(outWriteEnable), .outData(outData), .outFrameActive(outFrameActive),
    .outFrameDone(outFrameDone), .outFrameError(outFrameError), .outErrorCode(outErrorCode),
    .outFrameLength(outFrameLength), .outCrcOk(outCrcOk)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] crcByte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r[0] ^ d[i]) ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    return r;
  endfunction

  function automatic logic expCrc(input logic [7:0] pl[$]);
`ifdef RX_FRAME_CTRL_CRC_EN
    logic [15:0] r;
    r = '0;
    foreach (pl[i]) r = crcByte(r, pl[i]);
    return (r == 16'h0000);
`else
    return 1'b1;
`endif
  endfunction

  // Monitor: every write and every frame pulse must match the head of its queue
  always @(negedge clk) begin
    if (!rst) begin
      if (outWriteEnable) begin
        if (wrQ.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL unexpected write: got data %0b expected no write (cycle %0d)", outData, cyc);
        end else begin
          w = wrQ.pop_front();
          check("write data", 32'(outData), 32'(w.data));
          check("write cycle", cyc, w.cyc);
        end
      end
      if (outFrameDone || outFrameError) begin
        if (evQ.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL unexpected pulse: got done=%0b error=%0b expected none (cycle %0d)",
                   outFrameDone, outFrameError, cyc);
        end else begin
          e = evQ.pop_front();
          check("pulse done", 32'(outFrameDone), 32'(e.isDone));
          check("pulse error", 32'(outFrameError), 32'(!e.isDone));
          check("error code", 32'(outErrorCode), 32'(e.code));
          check("frame length", 32'(outFrameLength), 32'(e.len));
          check("crc ok", 32'(outCrcOk), 32'(e.crc));
        end
      end
    end
  end

  task automatic sendBit(input logic v, input logic expectWrite);
    @(negedge clk);
    bv = 1'b1; b = v;
    if (expectWrite) wrQ.push_back('{v, cyc + 1});
    @(negedge clk);
    bv = 1'b0; b = 1'b0;
    @(negedge clk);
  endtask

  task automatic sendByte(input logic [7:0] d, input logic expectWrite);
    for (int i = 0; i < 8; i++) sendBit(d[i], expectWrite);
  endtask

  task automatic sendHeader(input int pre, input logic [7:0] phr);
    for (int i = 0; i < pre; i++) sendBit(1'b0, 1'b0);
    sendByte(8'hA7, 1'b0);
    sendByte(phr, 1'b0);
  endtask

  task automatic drain(input string name, input int bound);
    for (int i = 0; i < bound && (wrQ.size() != 0 || evQ.size() != 0); i++) @(negedge clk);
    compared++;
    if (wrQ.size() != 0 || evQ.size() != 0) begin
      mismatched++;
      $display("FAIL %s drain: got %0d writes and %0d events outstanding expected 0", name,
               wrQ.size(), evQ.size());
      wrQ.delete(); evQ.delete();
    end
  endtask

  task automatic checkIdleOutputs(input string name);
    check({name, " we"}, 32'(outWriteEnable), 0);
    check({name, " data"}, 32'(outData), 0);
    check({name, " active"}, 32'(outFrameActive), 0);
    check({name, " done"}, 32'(outFrameDone), 0);
    check({name, " error"}, 32'(outFrameError), 0);
    check({name, " code"}, 32'(outErrorCode), 0);
    check({name, " length"}, 32'(outFrameLength), 0);
    check({name, " crc"}, 32'(outCrcOk), 1);
  endtask

  initial begin
    logic [7:0]  pl[$];
    logic [15:0] fcs;

    #23 checkIdleOutputs("reset");
    @(negedge clk); rst = 1'b0; en = 1'b1;

    // Asynchronous reset in the middle of a payload
    sendHeader(8, 8'h03);
    check("active in payload", 32'(outFrameActive), 1);
    for (int i = 0; i < 5; i++) sendBit(1'(i & 1), 1'b1);
    drain("pre-reset", 20);
    #2 rst = 1'b1;
    #1 checkIdleOutputs("mid-frame reset");
    @(negedge clk); rst = 1'b0;
    repeat (20) @(negedge clk);

    // Clean 3-byte frame after a long preamble
    pl = '{8'h5A, 8'hC3, 8'h0F};
    evQ.push_back('{1'b1, 2'b00, 7'd3, expCrc(pl)});
    sendHeader(32, 8'h03);
    foreach (pl[i]) sendByte(pl[i], 1'b1);
    drain("frame len3", 50);
    check("active after done", 32'(outFrameActive), 0);

    // Zero length, with and without the reserved bit
    evQ.push_back('{1'b0, 2'b01, 7'd3, 1'b1});
    sendHeader(8, 8'h00);
    drain("phr 00", 50);
    evQ.push_back('{1'b0, 2'b01, 7'd3, 1'b1});
    sendHeader(8, 8'h80);
    drain("phr 80", 50);

    // FIFO full on the 5th payload strobe
    evQ.push_back('{1'b0, 2'b10, 7'd2, 1'b1});
    sendHeader(8, 8'h02);
    sendBit(1'b1, 1'b1); sendBit(1'b0, 1'b1); sendBit(1'b1, 1'b1); sendBit(1'b1, 1'b1);
    full = 1'b1;
    sendBit(1'b1, 1'b0);
    full = 1'b0;
    drain("fifo full", 50);

    // Strobes stop after the 3rd payload bit
    evQ.push_back('{1'b0, 2'b11, 7'd1, 1'b1});
    sendHeader(8, 8'h01);
    sendBit(1'b0, 1'b1); sendBit(1'b1, 1'b1); sendBit(1'b1, 1'b1);
    drain("timeout", 5000);

    // Enable dropped mid-payload: silent abort
    sendHeader(8, 8'h01);
    sendBit(1'b1, 1'b1); sendBit(1'b0, 1'b1);
    drain("pre-disable", 20);
    en = 1'b0;
    @(negedge clk); @(negedge clk);
    check("active after disable", 32'(outFrameActive), 0);
    check("code after disable", 32'(outErrorCode), 0);
    repeat (4) @(negedge clk);
    en = 1'b1;

    // Frame carrying a correct FCS, then the same frame with a payload bit flipped
    fcs = crcByte(crcByte(16'h0000, 8'h31), 8'h32);
    pl = '{8'h31, 8'h32, fcs[7:0], fcs[15:8]};
    evQ.push_back('{1'b1, 2'b00, 7'd4, expCrc(pl)});
    sendHeader(8, 8'h04);
    foreach (pl[i]) sendByte(pl[i], 1'b1);
    drain("crc good", 50);
    pl[0] = 8'h30;
    evQ.push_back('{1'b1, 2'b00, 7'd4, expCrc(pl)});
    sendHeader(8, 8'h04);
    foreach (pl[i]) sendByte(pl[i], 1'b1);
    drain("crc flipped", 50);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
